// File: rtl/peripheral_bridge_ahb2apb_mux.sv
// AHB3-Lite slave to APB4 master bridge with a registered decoder fanning out to NUM_SLAVES peripherals.
// Optional ACCESS-phase timeout enabled by defining PERIPHERAL_BRIDGE_TIMEOUT_EN.
module peripheral_bridge_ahb2apb_mux #(
  parameter int unsigned HADDR_SIZE     = 16,
  parameter int unsigned HDATA_SIZE     = 32,
  parameter int unsigned PADDR_SIZE     = 8,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic                             HSEL,
  input  logic [HADDR_SIZE-1:0]            HADDR,
  input  logic [HDATA_SIZE-1:0]            HWDATA,
  output logic [HDATA_SIZE-1:0]            HRDATA,
  input  logic                             HWRITE,
  input  logic [2:0]                       HSIZE,
  input  logic [2:0]                       HBURST,
  input  logic [3:0]                       HPROT,
  input  logic [1:0]                       HTRANS,
  input  logic                             HMASTLOCK,
  input  logic                             HREADY,
  output logic                             HREADYOUT,
  output logic                             HRESP,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [2:0]                       PPROT,
  output logic                             PWRITE,
  output logic [HDATA_SIZE/8-1:0]          PSTRB,
  output logic [PADDR_SIZE-1:0]            PADDR,
  output logic [HDATA_SIZE-1:0]            PWDATA,
  input  logic [NUM_SLAVES*HDATA_SIZE-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int unsigned STRB_W   = HDATA_SIZE / 8;
  localparam int unsigned ALIGN_W  = $clog2(STRB_W);
  localparam int unsigned MAX_SIZE = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PADDR_SIZE-1:0]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             prot_q, prot_d;
  logic [HDATA_SIZE-1:0]  hrdata_q, hrdata_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic [NUM_SLAVES-1:0]  psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic [2:0]             pprot_q, pprot_d;
  logic                   pwrite_q, pwrite_d;
  logic [STRB_W-1:0]      pstrb_q, pstrb_d;
  logic [PADDR_SIZE-1:0]  paddr_q, paddr_d;
  logic [HDATA_SIZE-1:0]  pwdata_q, pwdata_d;

  logic [IDX_W-1:0]       dec_idx;
  logic                   accept;
  logic                   dec_err;

  if (NUM_SLAVES > 1) begin : g_dec_multi
    assign dec_idx = HADDR[PADDR_SIZE +: IDX_W];
  end else begin : g_dec_single
    assign dec_idx = '0;
  end

  assign accept  = HSEL & HREADY & HTRANS[1] & ((state_q == ST_IDLE) | (state_q == ST_ERR2));
  assign dec_err = (32'(dec_idx) >= NUM_SLAVES) | (HSIZE > 3'(MAX_SIZE));

  // Byte-lane mask for a transfer of 2**size bytes, aligned down to its natural boundary.
  function automatic logic [STRB_W-1:0] strb_f(input logic [2:0] size, input logic [ALIGN_W-1:0] lsb);
    logic [STRB_W-1:0]  base;
    logic [ALIGN_W-1:0] mask;
    case (size)
      3'd0:    base = STRB_W'(1);
      3'd1:    base = STRB_W'(3);
      3'd2:    base = STRB_W'(15);
      default: base = '1;
    endcase
    mask = (ALIGN_W'(1) << size) - ALIGN_W'(1);
    return base << (lsb & ~mask);
  endfunction

`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
  logic [TO_W-1:0] cnt_q, cnt_d;
`else
  logic unused_to;
  assign unused_to = ^32'(TIMEOUT_CYCLES);
`endif

  logic unused_in;
  assign unused_in = ^{HADDR, HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0]};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    prot_d    = prot_q;
    hrdata_d  = hrdata_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pstrb_d   = pstrb_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          idx_d   = dec_idx;
          addr_d  = HADDR[PADDR_SIZE-1:0];
          write_d = HWRITE;
          size_d  = HSIZE;
          prot_d  = HPROT[1:0];
          state_d = dec_err ? ST_ERR1 : ST_LATCH;
        end
      end
      ST_LATCH: begin
        pwdata_d = HWDATA;
        paddr_d  = addr_q;
        pwrite_d = write_q;
        pstrb_d  = write_q ? strb_f(size_q, addr_q[ALIGN_W-1:0]) : '0;
        pprot_d  = {~prot_q[0], 1'b1, prot_q[1]};
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY[idx_q]) begin
          if (PSLVERR[idx_q]) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_IDLE;
            if (!write_q) hrdata_d = PRDATA[32'(idx_q)*HDATA_SIZE +: HDATA_SIZE];
          end
        end
`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ERR1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
`endif
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // Bus-facing handshake outputs follow the state being entered.
    hreadyout_d = (state_d == ST_IDLE) | (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) | (state_d == ST_ERR2);
    penable_d   = (state_d == ST_ACCESS);
    psel_d      = ((state_d == ST_SETUP) | (state_d == ST_ACCESS)) ?
                  (NUM_SLAVES'(1) << idx_q) : '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      prot_q      <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      prot_q      <= prot_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PPROT     = pprot_q;
  assign PWRITE    = pwrite_q;
  assign PSTRB     = pstrb_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_peripheral_bridge_ahb2apb_mux.sv
// Directed bench for peripheral_bridge_ahb2apb_mux with three APB slaves.
module tb_peripheral_bridge_ahb2apb_mux;

  localparam int unsigned HA = 16;
  localparam int unsigned HD = 32;
  localparam int unsigned PA = 8;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = HD / 8;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic             HSEL;
  logic [HA-1:0]    HADDR;
  logic [HD-1:0]    HWDATA;
  logic [HD-1:0]    HRDATA;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [3:0]       HPROT;
  logic [1:0]       HTRANS;
  logic             HMASTLOCK;
  logic             HREADY;
  logic             HREADYOUT;
  logic             HRESP;
  logic [NS-1:0]    PSEL;
  logic             PENABLE;
  logic [2:0]       PPROT;
  logic             PWRITE;
  logic [SW-1:0]    PSTRB;
  logic [PA-1:0]    PADDR;
  logic [HD-1:0]    PWDATA;
  logic [NS*HD-1:0] PRDATA;
  logic [NS-1:0]    PREADY;
  logic [NS-1:0]    PSLVERR;

  int checks = 0;
  int errors = 0;
  int cur_wt = 0;
  logic cur_err = 1'b0;
  int acc_cnt = 0;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;
  // Slave model: the selected slave answers after cur_wt ACCESS cycles; unselected slaves drive the opposite level.
  assign PREADY  = (PENABLE && acc_cnt >= cur_wt) ? PSEL : ~PSEL;
  assign PSLVERR = cur_err ? PSEL : ~PSEL;

  always @(posedge HCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  peripheral_bridge_ahb2apb_mux #(
    .HADDR_SIZE(HA), .HDATA_SIZE(HD), .PADDR_SIZE(PA), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  prot;
    int          wt;
    logic        serr;
    logic [31:0] rdata;
    int          exp_low;
    logic        exp_resp;
    logic [2:0]  exp_psel;
    logic [7:0]  exp_paddr;
    logic [3:0]  exp_pstrb;
    logic [2:0]  exp_pprot;
    logic [31:0] exp_hrdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one AHB transfer starting at a negedge with HREADYOUT=1; returns at the negedge where HREADYOUT is back high.
  task automatic run_vec(input int id, input vec_t v);
    int low;
    logic resp_low, stable, c_pwrite;
    logic [NS-1:0] c_psel;
    logic [PA-1:0] c_paddr;
    logic [SW-1:0] c_pstrb;
    logic [2:0]    c_pprot;
    logic [HD-1:0] c_pwdata;
    int tgt;
    cur_wt  = v.wt;
    cur_err = v.serr;
    tgt = int'(v.addr[9:8]);
    for (int i = 0; i < NS; i++) PRDATA[i*HD +: HD] = (i == tgt) ? v.rdata : ~v.rdata;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size; HPROT = v.prot;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = v.wdata;
    low = 0; resp_low = 1'b0; stable = 1'b1;
    c_psel = '0; c_paddr = '0; c_pstrb = '0; c_pprot = '0; c_pwdata = '0; c_pwrite = 1'b0;
    while (HREADYOUT == 1'b0 && low < 60) begin
      if (PSEL != '0 && !PENABLE) begin
        c_psel = PSEL; c_paddr = PADDR; c_pstrb = PSTRB; c_pprot = PPROT;
        c_pwdata = PWDATA; c_pwrite = PWRITE;
      end else if (PENABLE && (PSEL != c_psel || PADDR != c_paddr || PSTRB != c_pstrb ||
                               PWDATA != c_pwdata || PWRITE != c_pwrite || PPROT != c_pprot)) begin
        stable = 1'b0;
      end
      resp_low = HRESP;
      low++;
      @(negedge HCLK);
    end
    check($sformatf("v%0d_low_cycles", id), 64'(low), 64'(v.exp_low));
    check($sformatf("v%0d_hresp_low", id), 64'(resp_low), 64'(v.exp_resp));
    check($sformatf("v%0d_hresp_after", id), 64'(HRESP), 64'(v.exp_resp));
    check($sformatf("v%0d_psel", id), 64'(c_psel), 64'(v.exp_psel));
    check($sformatf("v%0d_paddr", id), 64'(c_paddr), 64'(v.exp_paddr));
    check($sformatf("v%0d_pstrb", id), 64'(c_pstrb), 64'(v.exp_pstrb));
    check($sformatf("v%0d_pprot", id), 64'(c_pprot), 64'(v.exp_pprot));
    check($sformatf("v%0d_hrdata", id), 64'(HRDATA), 64'(v.exp_hrdata));
    check($sformatf("v%0d_apb_stable", id), 64'(stable), 64'(1'b1));
    if (v.exp_psel != '0) begin
      check($sformatf("v%0d_pwrite", id), 64'(c_pwrite), 64'(v.wr));
      if (v.wr) check($sformatf("v%0d_pwdata", id), 64'(c_pwdata), 64'(v.wdata));
    end
  endtask

  initial begin
    int n;
    vec_t tv;
    vecs[0] = '{16'h0104, 1'b1, 3'd2, 32'hDEADBEEF, 4'b0011, 0, 1'b0, 32'h0,
                3, 1'b0, 3'b010, 8'h04, 4'hF, 3'b011, 32'h0};
    vecs[1] = '{16'h0208, 1'b0, 3'd2, 32'h0, 4'b0000, 2, 1'b0, 32'h12345678,
                5, 1'b0, 3'b100, 8'h08, 4'h0, 3'b110, 32'h12345678};
    vecs[2] = '{16'h0003, 1'b1, 3'd0, 32'hAA000000, 4'b0001, 0, 1'b0, 32'h0,
                3, 1'b0, 3'b001, 8'h03, 4'b1000, 3'b010, 32'h12345678};
    vecs[3] = '{16'h0002, 1'b1, 3'd1, 32'hBEEF0000, 4'b0001, 0, 1'b0, 32'h0,
                3, 1'b0, 3'b001, 8'h02, 4'b1100, 3'b010, 32'h12345678};
    vecs[4] = '{16'h0101, 1'b1, 3'd0, 32'h0000CC00, 4'b0001, 1, 1'b0, 32'h0,
                4, 1'b0, 3'b010, 8'h01, 4'b0010, 3'b010, 32'h12345678};
    vecs[5] = '{16'h0300, 1'b0, 3'd2, 32'h0, 4'b0001, 0, 1'b0, 32'h0,
                1, 1'b1, 3'b000, 8'h00, 4'h0, 3'b000, 32'h12345678};
    vecs[6] = '{16'h0000, 1'b1, 3'd3, 32'h0, 4'b0001, 0, 1'b0, 32'h0,
                1, 1'b1, 3'b000, 8'h00, 4'h0, 3'b000, 32'h12345678};
    vecs[7] = '{16'h0110, 1'b0, 3'd2, 32'h0, 4'b0001, 0, 1'b1, 32'hFFFF0000,
                4, 1'b1, 3'b010, 8'h10, 4'h0, 3'b010, 32'h12345678};
    vecs[8] = '{16'h0010, 1'b0, 3'd2, 32'h0, 4'b0001, 1, 1'b0, 32'hCAFE0001,
                4, 1'b0, 3'b001, 8'h10, 4'h0, 3'b010, 32'hCAFE0001};
    vecs[9] = '{16'h0206, 1'b0, 3'd1, 32'h0, 4'b0001, 0, 1'b0, 32'h55AA33CC,
                3, 1'b0, 3'b100, 8'h06, 4'h0, 3'b010, 32'h55AA33CC};

    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = '0;
    HBURST = '0; HPROT = '0; HTRANS = '0; HMASTLOCK = 1'b0; PRDATA = '0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;

    check("rst_hreadyout", 64'(HREADYOUT), 64'(1'b1));
    check("rst_hresp", 64'(HRESP), 64'(1'b0));
    check("rst_hrdata", 64'(HRDATA), 64'(0));
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(1'b0));
    check("rst_pwrite", 64'(PWRITE), 64'(1'b0));
    check("rst_pstrb", 64'(PSTRB), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_pprot", 64'(PPROT), 64'(0));

    // IDLE and BUSY transfers get a zero-wait OKAY.
    HSEL = 1'b1; HADDR = 16'h0104; HTRANS = 2'b00;
    @(negedge HCLK);
    check("idle_hreadyout", 64'(HREADYOUT), 64'(1'b1));
    check("idle_psel", 64'(PSEL), 64'(0));
    HTRANS = 2'b01;
    @(negedge HCLK);
    check("busy_hreadyout", 64'(HREADYOUT), 64'(1'b1));
    check("busy_hresp", 64'(HRESP), 64'(1'b0));
    HSEL = 1'b0; HTRANS = 2'b00;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset asserted during ACCESS aborts the transfer on the next edge.
    cur_wt = 1000; cur_err = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 16'h0204; HWRITE = 1'b0; HSIZE = 3'd2; HPROT = 4'b0001;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    n = 0;
    while (!PENABLE && n < 10) begin
      n++;
      @(negedge HCLK);
    end
    check("rst_reach_access", 64'(PENABLE), 64'(1'b1));
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midrst_psel", 64'(PSEL), 64'(0));
    check("midrst_penable", 64'(PENABLE), 64'(1'b0));
    check("midrst_hreadyout", 64'(HREADYOUT), 64'(1'b1));
    check("midrst_hresp", 64'(HRESP), 64'(1'b0));
    HRESET = 1'b0;
    run_vec(10, vecs[0]);

`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
    tv = '{16'h0200, 1'b0, 3'd2, 32'h0, 4'b0001, 1000, 1'b0, 32'h0,
           7, 1'b1, 3'b100, 8'h00, 4'h0, 3'b010, 32'h0};
    run_vec(11, tv);
`else
    tv = vecs[9];
    tv.exp_hrdata = 32'h55AA33CC;
    run_vec(11, tv);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
